// File: rtl/systolic_result_drain.sv
// -----------------------------------------------------------------------------
// systolic_result_drain
//
// Purpose:
//   Downstream consumer of the systolic controller's 4x4 result matrix C.
//   On a rising edge of the controller's `completed` level, the whole matrix
//   is snapshotted into a local buffer. The buffer is then serialised, one
//   element per accepted beat, over a valid/ready stream. The block re-arms
//   only after `completed` drops again, so the controller holding `completed`
//   high in its fin state cannot trigger a second drain.
//
// Optional feature (macro SYSTOLIC_DRAIN_CHECKSUM_EN):
//   When defined, the frame gains a final extra beat carrying the sum of all
//   captured elements (mod 2^DATA_W). That beat carries out_last, and reports
//   out_row = out_col = 0. When undefined, the frame is exactly N*N beats and
//   no checksum logic exists.
//
// Parameters:
//   DATA_W    - element width and out_data width
//   N         - matrix dimension (N*N elements per frame)
//   COL_MAJOR - 0: row-major stream order, 1: column-major stream order
//
// Ports:
//   clk         in   rising-edge clock
//   st_rst      in   synchronous active-high reset (shared with controller)
//   completed   in   level from controller, high once C is valid
//   C           in   result matrix, C[row][col], DATA_W bits per element
//   out_data    out  current stream element
//   out_valid   out  out_data is valid
//   out_ready   in   sink accepts the beat when high together with out_valid
//   out_last    out  final beat of the frame
//   out_row     out  row index of the current beat
//   out_col     out  column index of the current beat
//   busy        out  high while a frame is being streamed
//   drain_done  out  high once the frame has fully drained
//   overrun     out  sticky: a new `completed` edge arrived mid-drain
// -----------------------------------------------------------------------------
module systolic_result_drain #(
  parameter int DATA_W    = 16,
  parameter int N         = 4,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic                            clk,
  input  logic                            st_rst,
  input  logic                            completed,
  input  logic [0:N-1][0:N-1][DATA_W-1:0] C,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [$clog2(N)-1:0]            out_row,
  output logic [$clog2(N)-1:0]            out_col,
  output logic                            busy,
  output logic                            drain_done,
  output logic                            overrun
);

  localparam int ROW_W = $clog2(N);
  localparam int ELEMS = N * N;

  // The index counter is sized for ELEMS+1 so both frame lengths share it.
  localparam int IDX_W = $clog2(ELEMS + 1);

`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
  localparam int LAST_IDX = ELEMS;
`else
  localparam int LAST_IDX = ELEMS - 1;
`endif

  localparam logic [IDX_W-1:0] FINAL_IDX = IDX_W'(LAST_IDX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            completed_q;
  logic                            overrun_q, overrun_d;
  logic [0:N-1][0:N-1][DATA_W-1:0] buffer_q;

  logic                            completedRise;
  logic                            capture;
  logic                            handshake;
  logic [31:0]                     idxWide;
  logic [ROW_W-1:0]                rowIdx;
  logic [ROW_W-1:0]                colIdx;
  logic                            isLastBeat;

`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0]               captureSum;
  logic [DATA_W-1:0]               checksum_q;
  logic                            isChecksumBeat;
`endif

  // A rising edge is judged against the previous cycle's level; since
  // completed_q resets low, a level already high out of reset counts too.
  assign completedRise = completed & ~completed_q;
  assign handshake     = (state_q == STREAM) & out_ready;
  assign isLastBeat    = (idx_q == FINAL_IDX);

  // Next-state logic. Capture happens on the IDLE->STREAM transition so the
  // first beat is presented in the cycle right after the edge is sampled.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    capture   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (completedRise) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (isLastBeat) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (!completed) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // A new result while the previous one is still draining (or not yet
    // re-armed) is dropped; the sticky flag records that it happened.
    if (completedRise && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // State, index, edge detector, error flag and snapshot buffer.
  always_ff @(posedge clk) begin
    if (st_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      completed_q <= 1'b0;
      overrun_q   <= 1'b0;
      buffer_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      completed_q <= completed;
      overrun_q   <= overrun_d;
      if (capture) begin
        buffer_q <= C;
      end
    end
  end

`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
  // Sum of the incoming matrix, registered alongside the snapshot so the
  // checksum always describes exactly the captured frame.
  always_comb begin
    captureSum = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        captureSum = captureSum + C[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (st_rst) begin
      checksum_q <= '0;
    end else if (capture) begin
      checksum_q <= captureSum;
    end
  end

  assign isChecksumBeat = (idx_q == IDX_W'(ELEMS));
`endif

  // Map the linear index onto matrix coordinates in the configured order.
  always_comb begin
    idxWide = 32'(idx_q);
    rowIdx  = ROW_W'(idxWide / N);
    colIdx  = ROW_W'(idxWide % N);
    if (COL_MAJOR) begin
      rowIdx = ROW_W'(idxWide % N);
      colIdx = ROW_W'(idxWide / N);
    end
`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
    if (isChecksumBeat) begin
      rowIdx = '0;
      colIdx = '0;
    end
`endif
  end

  // Stream outputs are forced to zero outside STREAM so nothing of a frame
  // remains visible after reset or after the drain completes.
  always_comb begin
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    out_row    = '0;
    out_col    = '0;
    busy       = 1'b0;
    drain_done = 1'b0;

    if (state_q == STREAM) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = isLastBeat;
      out_row   = rowIdx;
      out_col   = colIdx;
      out_data  = buffer_q[rowIdx][colIdx];
`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
      if (isChecksumBeat) begin
        out_data = checksum_q;
      end
`endif
    end

    if (state_q == DONE) begin
      drain_done = 1'b1;
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// -----------------------------------------------------------------------------
// tb_systolic_result_drain
//
// Purpose:
//   Self-checking bench for systolic_result_drain. Two instances share all
//   inputs: one streams row-major, the other column-major. Whenever a frame
//   is launched the bench pushes the expected beats of both orders into
//   per-instance queues; a monitor pops and compares on every accepted beat.
//   Define SYSTOLIC_DRAIN_CHECKSUM_EN for both bench and RTL to exercise the
//   checksum beat.
// -----------------------------------------------------------------------------
module tb_systolic_result_drain;

  localparam int DATA_W = 16;
  localparam int N      = 4;

`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
  localparam int BEATS = N * N + 1;
`else
  localparam int BEATS = N * N;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        row;
    logic [1:0]        col;
    logic              last;
  } beat_t;

  logic                            clk;
  logic                            st_rst;
  logic                            completed;
  logic                            out_ready;
  logic [0:N-1][0:N-1][DATA_W-1:0] cIn;

  logic [DATA_W-1:0] outData   [2];
  logic              outValid  [2];
  logic              outLast   [2];
  logic [1:0]        outRow    [2];
  logic [1:0]        outCol    [2];
  logic              busy      [2];
  logic              drainDone [2];
  logic              overrun   [2];

  logic [DATA_W-1:0] cModel [N][N];
  beat_t             expQ [2][$];
  int                acceptTotal [2];
  int                readyMode;
  int                compared;
  int                mismatched;

  systolic_result_drain #(.DATA_W(DATA_W), .N(N), .COL_MAJOR(1'b0)) dutRow (
    .clk        (clk),
    .st_rst     (st_rst),
    .completed  (completed),
    .C          (cIn),
    .out_data   (outData[0]),
    .out_valid  (outValid[0]),
    .out_ready  (out_ready),
    .out_last   (outLast[0]),
    .out_row    (outRow[0]),
    .out_col    (outCol[0]),
    .busy       (busy[0]),
    .drain_done (drainDone[0]),
    .overrun    (overrun[0])
  );

  systolic_result_drain #(.DATA_W(DATA_W), .N(N), .COL_MAJOR(1'b1)) dutCol (
    .clk        (clk),
    .st_rst     (st_rst),
    .completed  (completed),
    .C          (cIn),
    .out_data   (outData[1]),
    .out_valid  (outValid[1]),
    .out_ready  (out_ready),
    .out_last   (outLast[1]),
    .out_row    (outRow[1]),
    .out_col    (outCol[1]),
    .busy       (busy[1]),
    .drain_done (drainDone[1]),
    .overrun    (overrun[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setMatrixBasic();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        cModel[i][j] = DATA_W'(N * i + j + 1);
  endtask

  // Expected beats for both stream orders, built from the bench's matrix.
  task automatic pushFrame();
    beat_t             b;
    logic [DATA_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sum = sum + cModel[i][j];
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N * N; k++) begin
        int r;
        int c;
        r = (d == 0) ? k / N : k % N;
        c = (d == 0) ? k % N : k / N;
        b.data = cModel[r][c];
        b.row  = 2'(r);
        b.col  = 2'(c);
        b.last = (k == N * N - 1) && (BEATS == N * N);
        expQ[d].push_back(b);
      end
`ifdef SYSTOLIC_DRAIN_CHECKSUM_EN
      b.data = sum;
      b.row  = 2'd0;
      b.col  = 2'd0;
      b.last = 1'b1;
      expQ[d].push_back(b);
`endif
    end
  endtask

  // Drive the matrix, raise completed and register the expected frame.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        cIn[i][j] = cModel[i][j];
    completed = 1'b1;
    pushFrame();
  endtask

  task automatic waitFrameDone(input string tag, input int maxCycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      tick();
      done = (expQ[0].size() == 0) && (expQ[1].size() == 0) &&
             drainDone[0] && drainDone[1];
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  // Sink ready: held high, or the repeating 1,0,0,1 backpressure pattern.
  initial begin
    int phase;
    phase     = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 1) begin
        out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
        phase++;
      end else begin
        out_ready = 1'b1;
        phase     = 0;
      end
    end
  end

  // Monitor: compares every accepted beat against the scoreboard and checks
  // that a stalled beat stays put until it is accepted.
  initial begin
    bit    stallPrev [2];
    beat_t heldBeat  [2];
    beat_t curBeat;
    beat_t expBeat;
    stallPrev = '{1'b0, 1'b0};
    heldBeat  = '{'0, '0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        curBeat = {outData[d], outRow[d], outCol[d], outLast[d]};
        if (st_rst) begin
          stallPrev[d] = 1'b0;
        end else begin
          if (stallPrev[d]) begin
            checkOutput($sformatf("dut%0d.stallValid", d), 32'(outValid[d]), 32'd1);
            checkOutput($sformatf("dut%0d.stallBeat", d), 32'(curBeat), 32'(heldBeat[d]));
          end
          if (outValid[d] && out_ready) begin
            checkOutput($sformatf("dut%0d.queueNonEmpty", d),
                        32'(expQ[d].size() != 0), 32'd1);
            if (expQ[d].size() != 0) begin
              expBeat = expQ[d].pop_front();
              checkOutput($sformatf("dut%0d.data", d), 32'(outData[d]), 32'(expBeat.data));
              checkOutput($sformatf("dut%0d.row", d), 32'(outRow[d]), 32'(expBeat.row));
              checkOutput($sformatf("dut%0d.col", d), 32'(outCol[d]), 32'(expBeat.col));
              checkOutput($sformatf("dut%0d.last", d), 32'(outLast[d]), 32'(expBeat.last));
            end
            acceptTotal[d]++;
            stallPrev[d] = 1'b0;
          end else if (outValid[d]) begin
            stallPrev[d] = 1'b1;
            heldBeat[d]  = curBeat;
          end else begin
            stallPrev[d] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int base;
    compared    = 0;
    mismatched  = 0;
    readyMode   = 0;
    acceptTotal = '{0, 0};
    st_rst      = 1'b1;
    completed   = 1'b0;
    cIn         = '0;
    setMatrixBasic();

    // Reset state
    tick();
    tick();
    checkOutput("rst.valid", 32'(outValid[0]), 32'd0);
    checkOutput("rst.busy", 32'(busy[0]), 32'd0);
    checkOutput("rst.drainDone", 32'(drainDone[0]), 32'd0);
    checkOutput("rst.overrun", 32'(overrun[0]), 32'd0);
    checkOutput("rst.data", 32'(outData[0]), 32'd0);
    st_rst = 1'b0;

    // Test 1: basic drain with completed raised at cycle 5 and held
    $display("[TB] basic drain");
    repeat (4) tick();
    base = acceptTotal[0];
    applyStimulus();
    repeat (BEATS) tick();
    checkOutput("t1.lastBeatValid", 32'(outValid[0]), 32'd1);
    checkOutput("t1.lastBeatFlag", 32'(outLast[0]), 32'd1);
    checkOutput("t1.notDoneYet", 32'(drainDone[0]), 32'd0);
    tick();
    checkOutput("t1.drainDone", 32'(drainDone[0]), 32'd1);
    checkOutput("t1.busyLow", 32'(busy[0]), 32'd0);
    checkOutput("t1.validLow", 32'(outValid[0]), 32'd0);
    repeat (20) tick();
    checkOutput("t1.beats", 32'(acceptTotal[0] - base), 32'(BEATS));
    checkOutput("t1.queueEmpty", 32'(expQ[0].size() + expQ[1].size()), 32'd0);
    checkOutput("t1.stillDone", 32'(drainDone[0]), 32'd1);

    // Test 2: backpressure with ready pattern 1,0,0,1
    $display("[TB] backpressure");
    completed = 1'b0;
    tick();
    tick();
    checkOutput("t2.rearmIdle", 32'(drainDone[0]), 32'd0);
    readyMode = 1;
    base = acceptTotal[0];
    applyStimulus();
    waitFrameDone("t2.frameDone", 200);
    checkOutput("t2.beats", 32'(acceptTotal[0] - base), 32'(BEATS));
    readyMode = 0;

    // Test 3: buffer isolation, then re-arm with new data
    $display("[TB] buffer isolation and re-arm");
    completed = 1'b0;
    tick();
    tick();
    applyStimulus();
    tick();
    tick();
    cIn = {N * N{16'hFFFF}};
    waitFrameDone("t3.frame1Done", 200);
    completed = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        cModel[i][j] = DATA_W'(16'h0100 + N * i + j);
    applyStimulus();
    waitFrameDone("t3.frame2Done", 200);
    checkOutput("t3.overrunRow", 32'(overrun[0]), 32'd0);
    checkOutput("t3.overrunCol", 32'(overrun[1]), 32'd0);

    // Test 4: reset after 7 accepted beats, completed kept high
    $display("[TB] reset mid-frame");
    completed = 1'b0;
    tick();
    tick();
    setMatrixBasic();
    base = acceptTotal[0];
    applyStimulus();
    for (int i = 0; i < 100 && (acceptTotal[0] - base) != 7; i++) tick();
    checkOutput("t4.sevenBeats", 32'(acceptTotal[0] - base), 32'd7);
    st_rst = 1'b1;
    tick();
    checkOutput("t4.validAfterRst", 32'(outValid[0]), 32'd0);
    checkOutput("t4.dataAfterRst", 32'(outData[0]), 32'd0);
    checkOutput("t4.busyAfterRst", 32'(busy[1]), 32'd0);
    expQ[0].delete();
    expQ[1].delete();
    st_rst = 1'b0;
    base = acceptTotal[0];
    pushFrame();
    waitFrameDone("t4.freshFrameDone", 200);
    checkOutput("t4.beats", 32'(acceptTotal[0] - base), 32'(BEATS));
    checkOutput("t4.overrun", 32'(overrun[0]), 32'd0);

    // Overrun: a fresh completed edge while streaming is flagged and dropped
    $display("[TB] overrun");
    completed = 1'b0;
    tick();
    tick();
    applyStimulus();
    tick();
    tick();
    tick();
    completed = 1'b0;
    tick();
    completed = 1'b1;
    tick();
    checkOutput("ovr.setRow", 32'(overrun[0]), 32'd1);
    checkOutput("ovr.setCol", 32'(overrun[1]), 32'd1);
    waitFrameDone("ovr.frameDone", 200);
    repeat (10) tick();
    checkOutput("ovr.sticky", 32'(overrun[0]), 32'd1);
    checkOutput("ovr.noRecapture", 32'(expQ[0].size()), 32'd0);
    completed = 1'b0;
    st_rst    = 1'b1;
    tick();
    checkOutput("ovr.clearedByRst", 32'(overrun[0]), 32'd0);
    st_rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
